reg_serializer: RTL and testbench
=================================

Name: reg_serializer

Overview:
- Parallel-in, serial-out transmitter for the 4-bit register datapath.
- Accepts one parallel word through a valid/ready load handshake, then shifts it out one bit per enabled clock.
- Emits first/last framing flags and a completion pulse.
- Serves as the other end of the parallel register load path: serial links and bench monitors read stored words through it.

Parameters:
- WIDTH, 4, word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 sends data_in[WIDTH-1] first, 0 sends data_in[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  data_in is valid and requests transmission.
- load_ready  output  1  block can accept a word; high only in IDLE.
- shift_en  input  1  downstream consumes the current bit at this edge.
- ser_out  output  1  current serial bit; 0 when ser_valid=0.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_first  output  1  current bit is bit 0 of the frame.
- ser_last  output  1  current bit is bit WIDTH-1 of the frame.
- busy  output  1  high in the SHIFT state.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is asynchronous and active-high.
- Reset state (applied immediately on rst, independent of clk):
  - state = IDLE; shift register and bit counter = 0.
  - ser_out, ser_valid, ser_first, ser_last, busy, done = 0.
  - load_ready = 1.
- State machine (all outputs registered):
  - IDLE:
    - load_ready = 1, ser_valid = 0.
    - On an edge with load_valid = 1: capture data_in into the shift register, clear the counter, go to SHIFT.
  - SHIFT:
    - load_ready = 0, busy = 1, ser_valid = 1.
    - ser_out = shreg[WIDTH-1] when MSB_FIRST = 1, else shreg[0].
    - ser_first = (cnt == 0); ser_last = (cnt == WIDTH-1).
    - Edge with shift_en = 1 and cnt < WIDTH-1: shift toward the output end, cnt += 1.
    - Edge with shift_en = 1 and cnt == WIDTH-1: go to IDLE and set done = 1 for exactly that next cycle.
    - Edge with shift_en = 0: hold all state (stall); no bit is dropped or repeated.
- Timing:
  - First bit is valid the cycle after the load edge.
  - With shift_en held at 1, the last bit is consumed WIDTH edges after load.
  - done and load_ready = 1 appear together in the cycle after that.
  - Minimum load-to-load period is WIDTH+1 cycles.
- Boundary conditions:
  - load_valid during SHIFT is ignored; data_in is not sampled; the in-flight word is unaffected.
  - A load is accepted in the same cycle done is high (back-to-back frames).
  - shift_en in IDLE has no effect.
  - Counter width is clog2(WIDTH); it never exceeds WIDTH-1.
  - Vacated shift-register bits fill with 0.
  - rst asserted mid-frame aborts the frame immediately: remaining bits are lost and done is not pulsed. The first edge after rst deasserts is handled as IDLE.
  - data_in must be stable only at the accepting edge.

Test Plan:
1. Reset: assert rst between edges -> all outputs reach reset values before the next edge; load_ready = 1.
2. MSB_FIRST = 1, load 4'b1011, shift_en = 1 -> ser_out 1,0,1,1 over 4 cycles; ser_first on bit 1, ser_last on bit 4; done one cycle after, with load_ready = 1.
3. MSB_FIRST = 0, load 4'b1011 -> ser_out 1,1,0,1; same flag and done timing as scenario 2.
4. Load 4'b0110, drop shift_en for 3 cycles after bit 2 -> ser_out holds 1 (bit 2) with ser_valid = 1 through the stall; resumes with 1,0; total 4 bits, done once.
5. Load 4'b1100 and hold load_valid with data_in = 4'b0011 during SHIFT -> output 1,1,0,0 only; the 4'b0011 is accepted on the done cycle and transmitted next as 0,0,1,1.
6. Load 4'b1111, assert rst after bit 2 -> outputs clear immediately, no done pulse; next load 4'b1001 -> 1,0,0,1 with correct flags.

Source files
------------

// File: rtl/reg_serializer_if.sv
// Load/serial bus for reg_serializer: parallel load handshake on one side,
// framed serial bit stream plus status on the other.
interface reg_serializer_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             busy;
   logic             done;

   modport master (
      output data_in, load_valid, shift_en,
      input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
   );

   modport slave (
      input  data_in, load_valid, shift_en,
      output load_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
   );
endinterface

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out transmitter: accepts one word per valid/ready load,
// shifts it out one bit per shift_en edge with first/last framing and a done pulse.
module reg_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             rst,
   reg_serializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [0:0]       state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             done_nxt;
   logic             out_bit_nxt;
   logic             shifting_nxt;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_valid) begin
               shreg_nxt = bus.data_in;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.shift_en) begin
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  shreg_nxt = '0;
                  cnt_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  // Move the next bit toward the output end; vacated bits fill with 0.
                  shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg[WIDTH-1:1]};
                  cnt_nxt   = cnt + CW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      shifting_nxt = (state_nxt == SHIFT);
      out_bit_nxt  = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
   end

   // Outputs are registered from the next-state values so they line up with state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         shreg          <= '0;
         cnt            <= '0;
         bus.ser_out    <= 1'b0;
         bus.ser_valid  <= 1'b0;
         bus.ser_first  <= 1'b0;
         bus.ser_last   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.load_ready <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state          <= state_nxt;
         shreg          <= shreg_nxt;
         cnt            <= cnt_nxt;
         bus.ser_out    <= shifting_nxt & out_bit_nxt;
         bus.ser_valid  <= shifting_nxt;
         bus.ser_first  <= shifting_nxt & (cnt_nxt == '0);
         bus.ser_last   <= shifting_nxt & (cnt_nxt == LAST);
         bus.busy       <= shifting_nxt;
         bus.done       <= done_nxt;
         bus.load_ready <= ~shifting_nxt;
      end
   end
endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: table of per-cycle vectors on an MSB-first
// and an LSB-first instance, plus hand-written reset sequences.
module tb_reg_serializer;
   localparam int WIDTH = 4;
   localparam int NV    = 31;

   // Output vector order: {ser_out, ser_valid, ser_first, ser_last, load_ready, busy, done}
   localparam logic [6:0] IDLE_V = 7'b0000100;

   typedef struct packed {
      logic       sel;   // 0: MSB-first instance, 1: LSB-first instance
      logic       lv;
      logic [3:0] d;
      logic       se;
      logic [6:0] want;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [0:NV-1];

   always #5 clk = ~clk;

   reg_serializer_if #(.WIDTH(WIDTH)) bus_m ();
   reg_serializer_if #(.WIDTH(WIDTH)) bus_l ();

   reg_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
   reg_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

   function automatic logic [6:0] outs(input logic sel);
      if (sel)
         return {bus_l.ser_out, bus_l.ser_valid, bus_l.ser_first, bus_l.ser_last,
                 bus_l.load_ready, bus_l.busy, bus_l.done};
      return {bus_m.ser_out, bus_m.ser_valid, bus_m.ser_first, bus_m.ser_last,
              bus_m.load_ready, bus_m.busy, bus_m.done};
   endfunction

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%b want=%b", name, got, want);
      end
   endtask

   // Drive one instance for one cycle, the other idles; compare #1 after the edge.
   task automatic step(input logic sel, input logic lv, input logic [3:0] d,
                       input logic se, input logic [6:0] want, input string name);
      bus_m.load_valid = ~sel & lv;
      bus_m.data_in    = sel ? 4'b0000 : d;
      bus_m.shift_en   = ~sel & se;
      bus_l.load_valid = sel & lv;
      bus_l.data_in    = sel ? d : 4'b0000;
      bus_l.shift_en   = sel & se;
      @(posedge clk);
      #1;
      check(name, outs(sel), want);
   endtask

   initial begin
      // MSB first, load 1011: bits 1,0,1,1 then done, then shift_en in IDLE
      vecs[0]  = '{1'b0, 1'b1, 4'b1011, 1'b1, 7'b1110010};
      vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0100010};
      vecs[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1100010};
      vecs[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1101010};
      vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0000101};
      vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, IDLE_V};
      // Load 0110, stall 3 cycles on bit 2
      vecs[6]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 7'b0110010};
      vecs[7]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1100010};
      vecs[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1100010};
      vecs[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1100010};
      vecs[10] = '{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1100010};
      vecs[11] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1100010};
      vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0101010};
      vecs[13] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0000101};
      // Load 1100 on the done cycle, hold load_valid with 0011; 0011 follows back-to-back
      vecs[14] = '{1'b0, 1'b1, 4'b1100, 1'b1, 7'b1110010};
      vecs[15] = '{1'b0, 1'b1, 4'b0011, 1'b1, 7'b1100010};
      vecs[16] = '{1'b0, 1'b1, 4'b0011, 1'b1, 7'b0100010};
      vecs[17] = '{1'b0, 1'b1, 4'b0011, 1'b1, 7'b0101010};
      vecs[18] = '{1'b0, 1'b1, 4'b0011, 1'b1, 7'b0000101};
      vecs[19] = '{1'b0, 1'b1, 4'b0011, 1'b1, 7'b0110010};
      vecs[20] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0100010};
      vecs[21] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1100010};
      vecs[22] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b1101010};
      vecs[23] = '{1'b0, 1'b0, 4'b0000, 1'b1, 7'b0000101};
      vecs[24] = '{1'b0, 1'b0, 4'b0000, 1'b1, IDLE_V};
      // LSB first, load 1011: bits 1,1,0,1
      vecs[25] = '{1'b1, 1'b1, 4'b1011, 1'b1, 7'b1110010};
      vecs[26] = '{1'b1, 1'b0, 4'b0000, 1'b1, 7'b1100010};
      vecs[27] = '{1'b1, 1'b0, 4'b0000, 1'b1, 7'b0100010};
      vecs[28] = '{1'b1, 1'b0, 4'b0000, 1'b1, 7'b1101010};
      vecs[29] = '{1'b1, 1'b0, 4'b0000, 1'b1, 7'b0000101};
      vecs[30] = '{1'b1, 1'b0, 4'b0000, 1'b1, IDLE_V};

      bus_m.data_in = '0; bus_m.load_valid = 1'b0; bus_m.shift_en = 1'b0;
      bus_l.data_in = '0; bus_l.load_valid = 1'b0; bus_l.shift_en = 1'b0;

      // Reset between edges takes effect without a clock edge
      #1 rst = 1'b1;
      #1;
      check("reset_async_msb", outs(1'b0), IDLE_V);
      check("reset_async_lsb", outs(1'b1), IDLE_V);
      @(posedge clk);
      #3 rst = 1'b0;

      for (int i = 0; i < NV; i++)
         step(vecs[i].sel, vecs[i].lv, vecs[i].d, vecs[i].se, vecs[i].want,
              $sformatf("row%0d", i));

      // Mid-frame reset: load 1111, abort after bit 2, then load 1001
      step(1'b0, 1'b1, 4'b1111, 1'b1, 7'b1110010, "abort_b1");
      step(1'b0, 1'b0, 4'b0000, 1'b1, 7'b1100010, "abort_b2");
      #2 rst = 1'b1;
      #1;
      check("abort_rst_async", outs(1'b0), IDLE_V);
      step(1'b0, 1'b0, 4'b0000, 1'b1, IDLE_V, "abort_rst_held");
      #2 rst = 1'b0;
      step(1'b0, 1'b0, 4'b0000, 1'b1, IDLE_V, "abort_no_done");
      step(1'b0, 1'b1, 4'b1001, 1'b1, 7'b1110010, "reload_b1");
      step(1'b0, 1'b0, 4'b0000, 1'b1, 7'b0100010, "reload_b2");
      step(1'b0, 1'b0, 4'b0000, 1'b1, 7'b0100010, "reload_b3");
      step(1'b0, 1'b0, 4'b0000, 1'b1, 7'b1101010, "reload_b4");
      step(1'b0, 1'b0, 4'b0000, 1'b1, 7'b0000101, "reload_done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
